// File: rtl/cdr_pkg.sv
// Shared types and constants for the CDR frame synchroniser.
package cdr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } cdr_state_t;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA7;

  // Frame bit counter must hold FRAME_LEN-1; 8 bits covers frames up to 256 bits.
  localparam int BIT_CNT_W  = 8;
  // Hit and miss counters cover the 1..15 lock/loss thresholds.
  localparam int HIT_CNT_W  = 4;
  localparam int MISS_CNT_W = 4;
  localparam int ERR_CNT_W  = 8;

  function automatic int frame_len(input int sync_w, input int payload_bytes);
    return sync_w + 8 * payload_bytes;
  endfunction

endpackage

// File: rtl/cdr_frame_sync_byte_assembler.sv
// Payload byte assembler: collects eight MSB-first bits into a registered byte.
// A clear discards any partial byte so every frame starts on a byte boundary.
module cdr_byte_assembler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift,
  input  logic       clear,
  input  logic       bit_in,
  output logic [7:0] byte_out,
  output logic       byte_valid
);

  logic [6:0] sr;
  logic [2:0] idx;

  // Shift payload bits in; on the eighth bit publish the byte for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr         <= '0;
      idx        <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (shift) begin
        if (idx == 3'd7) begin
          byte_out   <= {sr, bit_in};
          byte_valid <= 1'b1;
          sr         <= '0;
          idx        <= '0;
        end else begin
          sr  <= {sr[5:0], bit_in};
          idx <= idx + 3'd1;
        end
      end else if (clear) begin
        sr  <= '0;
        idx <= '0;
      end
    end
  end

endmodule

// File: rtl/cdr_frame_sync.sv
// Frame synchroniser for the CDR recovered bit stream: hunts for the sync
// word, verifies alignment over consecutive frames, then emits payload bytes
// while a flywheel rides through isolated sync errors.
//
// state  | meaning
// HUNT   | sliding compare of every bit against the sync word, no output
// VERIFY | candidate alignment found, counting consecutive sync hits
// LOCKED | aligned; payload bytes emitted, sync misses tracked
module cdr_frame_sync
  import cdr_pkg::*;
#(
  parameter int               SYNC_W        = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD    = SYNC_W'(SYNC_WORD_DEFAULT),
  parameter int               PAYLOAD_BYTES = 4,
  parameter int               LOCK_CNT      = 2,
  parameter int               LOSS_CNT      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [1:0] state_o,
  output logic [7:0] sync_err_cnt
);

  localparam int FRAME_LEN = frame_len(SYNC_W, PAYLOAD_BYTES);
  localparam logic [BIT_CNT_W-1:0] LAST_CNT     = BIT_CNT_W'(FRAME_LEN - 1);
  localparam logic [BIT_CNT_W-1:0] PAYLOAD_BITS = BIT_CNT_W'(8 * PAYLOAD_BYTES);
  localparam logic [BIT_CNT_W-1:0] FIRST_BYTE_END = BIT_CNT_W'(7);
  localparam logic [HIT_CNT_W-1:0]  LOCK_TH = HIT_CNT_W'(LOCK_CNT);
  localparam logic [MISS_CNT_W-1:0] LOSS_TH = MISS_CNT_W'(LOSS_CNT);

  cdr_state_t            state, state_next;
  logic [SYNC_W-1:0]     sr, sr_next;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [HIT_CNT_W-1:0]  hits, hits_next, hits_inc;
  logic [MISS_CNT_W-1:0] misses, misses_next, misses_inc;
  logic [ERR_CNT_W-1:0]  err_cnt, err_next;
  logic                  frame_start_next;
  logic                  asm_shift, asm_clear;
  logic                  bit_evt, sync_hit, at_check, in_payload;

  assign bit_evt    = ena & bit_valid;
  assign sr_next    = {sr[SYNC_W-2:0], bit_in};
  assign sync_hit   = (sr_next == SYNC_WORD);
  assign at_check   = (bit_cnt == LAST_CNT);
  assign in_payload = (bit_cnt < PAYLOAD_BITS);
  assign hits_inc   = hits + 1'b1;
  assign misses_inc = misses + 1'b1;

  // State and counter registers; everything holds unless a bit event occurs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      sr          <= '0;
      bit_cnt     <= '0;
      hits        <= '0;
      misses      <= '0;
      err_cnt     <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      hits        <= hits_next;
      misses      <= misses_next;
      err_cnt     <= err_next;
      frame_start <= frame_start_next;
      if (bit_evt) begin
        sr <= sr_next;
      end
    end
  end

  // Next-state, frame position tracking and assembler control.
  always_comb begin
    state_next       = state;
    bit_cnt_next     = bit_cnt;
    hits_next        = hits;
    misses_next      = misses;
    err_next         = err_cnt;
    frame_start_next = 1'b0;
    asm_shift        = 1'b0;
    asm_clear        = 1'b0;

    if (bit_evt) begin
      case (state)
        HUNT: begin
          asm_clear = 1'b1;
          if (sync_hit) begin
            state_next   = VERIFY;
            bit_cnt_next = '0;
            hits_next    = HIT_CNT_W'(1);
          end
        end

        VERIFY: begin
          asm_clear = 1'b1;
          if (at_check) begin
            bit_cnt_next = '0;
            if (sync_hit) begin
              hits_next = hits_inc;
              if (hits_inc == LOCK_TH) begin
                state_next  = LOCKED;
                misses_next = '0;
              end
            end else begin
              state_next = HUNT;
              hits_next  = '0;
            end
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end

        LOCKED: begin
          if (in_payload) begin
            asm_shift        = 1'b1;
            frame_start_next = (bit_cnt == FIRST_BYTE_END);
          end
          if (at_check) begin
            asm_clear    = 1'b1;
            bit_cnt_next = '0;
            if (sync_hit) begin
              misses_next = '0;
            end else begin
              misses_next = misses_inc;
              if (err_cnt != '1) begin
                err_next = err_cnt + 1'b1;
              end
              if (misses_inc == LOSS_TH) begin
                state_next  = HUNT;
                hits_next   = '0;
                misses_next = '0;
              end
            end
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end

        default: begin
          state_next   = HUNT;
          bit_cnt_next = '0;
          hits_next    = '0;
          misses_next  = '0;
        end
      endcase
    end
  end

  cdr_byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift      (asm_shift),
    .clear      (asm_clear),
    .bit_in     (bit_in),
    .byte_out   (byte_out),
    .byte_valid (byte_valid)
  );

  assign locked       = (state == LOCKED);
  assign state_o      = state;
  assign sync_err_cnt = err_cnt;

endmodule

// File: tb/tb_cdr_frame_sync.sv
// Directed bench for cdr_frame_sync: frame-level vector table plus
// hand-written reset, false-sync, gapped/ena and saturation sequences.
module tb_cdr_frame_sync;
  import cdr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_start;
  logic       locked;
  logic [1:0] state_o;
  logic [7:0] sync_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdr_frame_sync dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .frame_start  (frame_start),
    .locked       (locked),
    .state_o      (state_o),
    .sync_err_cnt (sync_err_cnt)
  );

  typedef struct packed {
    logic [7:0] sync;
    logic [1:0] st;
    logic [7:0] err;
    logic [2:0] nbytes;
  } row_t;

  row_t rows [10];
  logic [7:0] payload [4];

  logic [7:0] got_q [$];
  logic       fs_q  [$];
  logic       prev_bv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (byte_valid || frame_start) begin
      chk("fs_without_bv", 32'(frame_start & ~byte_valid), 32'd0);
      chk("bv_one_cycle", 32'(byte_valid & prev_bv), 32'd0);
    end
    if (byte_valid) begin
      got_q.push_back(byte_out);
      fs_q.push_back(frame_start);
    end
    prev_bv = byte_valid;
  end

  task automatic send_bit(input logic b, input int gap);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
    repeat (gap) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic do_pause();
    int n0;
    n0 = got_q.size();
    @(negedge clk);
    ena = 1'b0;
    repeat (10) begin
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("pause_state", 32'(state_o), 32'(LOCKED));
    chk("pause_nbytes", 32'(got_q.size() - n0), 32'd0);
    ena       = 1'b1;
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input int pause_at);
    for (int i = 7; i >= 0; i--) begin
      if (i == pause_at) do_pause();
      send_bit(b[i], gap);
    end
  endtask

  task automatic send_frame(input logic [7:0] sync, input int gap, input int pause_at);
    for (int j = 0; j < 4; j++) begin
      send_byte(payload[j], gap, (j == 1) ? pause_at : -1);
    end
    send_byte(sync, gap, -1);
  endtask

  task automatic run_row(input row_t r, input int gap, input int pause_at);
    int base;
    base = got_q.size();
    send_frame(r.sync, gap, pause_at);
    idle();
    chk("row_state", 32'(state_o), 32'(r.st));
    chk("row_locked", 32'(locked), 32'(r.st == LOCKED));
    chk("row_err", 32'(sync_err_cnt), 32'(r.err));
    chk("row_nbytes", 32'(got_q.size() - base), 32'(r.nbytes));
    if (r.nbytes == 3'd4 && got_q.size() - base == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("row_byte", 32'(got_q[base + k]), 32'(payload[k]));
        chk("row_fs", 32'(fs_q[base + k]), 32'(k == 0));
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_byte_out"}, 32'(byte_out), 32'd0);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_err"}, 32'(sync_err_cnt), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bit_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    payload[0] = 8'h11;
    payload[1] = 8'h22;
    payload[2] = 8'h33;
    payload[3] = 8'h44;
    //            sync   state   err    bytes
    rows[0] = '{8'hA7, LOCKED, 8'd0, 3'd0};
    rows[1] = '{8'hA7, LOCKED, 8'd0, 3'd4};
    rows[2] = '{8'hA6, LOCKED, 8'd1, 3'd4};
    rows[3] = '{8'hA7, LOCKED, 8'd1, 3'd4};
    rows[4] = '{8'hA6, LOCKED, 8'd2, 3'd4};
    rows[5] = '{8'hA6, LOCKED, 8'd3, 3'd4};
    rows[6] = '{8'hA6, HUNT,   8'd4, 3'd4};
    rows[7] = '{8'hA7, VERIFY, 8'd4, 3'd0};
    rows[8] = '{8'hA7, LOCKED, 8'd4, 3'd0};
    rows[9] = '{8'hA7, LOCKED, 8'd4, 3'd4};

    // Reset held 5 clocks with random strobes.
    ena = 1'b1;
    repeat (5) begin
      @(negedge clk);
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
    end
    chk_reset_vals("reset");
    rst_n     = 1'b1;
    bit_valid = 1'b0;

    // Clean acquisition, flywheel, loss and relock.
    send_byte(8'hA7, 0, -1);
    idle();
    chk("first_sync_verify", 32'(state_o), 32'(VERIFY));
    for (int i = 0; i < 10; i++) run_row(rows[i], 0, -1);

    // Reset mid-byte while locked.
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    pulse_reset();
    chk_reset_vals("midreset");

    // False sync: A7 inside data, next sync slot wrong.
    base = got_q.size();
    send_byte(8'h55, 0, -1);
    send_byte(8'hA7, 0, -1);
    idle();
    chk("false_verify", 32'(state_o), 32'(VERIFY));
    send_byte(8'h01, 0, -1);
    send_byte(8'h02, 0, -1);
    send_byte(8'h03, 0, -1);
    send_byte(8'h04, 0, -1);
    send_byte(8'h00, 0, -1);
    idle();
    chk("false_hunt", 32'(state_o), 32'(HUNT));
    chk("false_locked", 32'(locked), 32'd0);
    chk("false_nbytes", 32'(got_q.size() - base), 32'd0);

    // Gapped strobes with an ena pause in the middle of payload byte 1.
    pulse_reset();
    send_byte(8'hA7, 3, -1);
    idle();
    chk("gap_verify", 32'(state_o), 32'(VERIFY));
    run_row(rows[0], 3, -1);
    run_row(rows[1], 3, 3);

    // Error counter saturation via repeated relock and triple miss.
    pulse_reset();
    for (int it = 1; it <= 100; it++) begin
      send_frame(8'hA7, 0, -1);
      send_frame(8'hA7, 0, -1);
      send_frame(8'hA6, 0, -1);
      send_frame(8'hA6, 0, -1);
      send_frame(8'hA6, 0, -1);
      if (it == 1 || it == 84 || it == 86) begin
        idle();
        chk("sat_state", 32'(state_o), 32'(HUNT));
        chk("sat_err", 32'(sync_err_cnt), (it == 1) ? 32'd3 : (it == 84) ? 32'd252 : 32'd255);
      end
    end
    idle();
    chk("sat_final_err", 32'(sync_err_cnt), 32'd255);
    chk("sat_final_state", 32'(state_o), 32'(HUNT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
